// File: rtl/fat_chain_sector_builder_if.sv
// Request/completion handshake plus sector-buffer write port of the FAT sector builder.
interface fat_chain_sector_builder_if #(
    parameter int AW = 7
);
    logic          START;
    logic [23:0]   SECTOR_IDX;
    logic [31:0]   BEGIN_CLUST;
    logic [31:0]   EOF_CLUST;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic          WENA_SW;
    logic [AW-1:0] WADDR_SW;
    logic [31:0]   INPUT_SW;

    modport master (
        output START, SECTOR_IDX, BEGIN_CLUST, EOF_CLUST,
        input  BUSY, DONE, ERR, WENA_SW, WADDR_SW, INPUT_SW
    );

    modport slave (
        input  START, SECTOR_IDX, BEGIN_CLUST, EOF_CLUST,
        output BUSY, DONE, ERR, WENA_SW, WADDR_SW, INPUT_SW
    );
endinterface

// File: rtl/fat_chain_sector_builder.sv
// Builds one FAT sector holding a contiguous cluster chain and streams it, one
// registered word per cycle, into the sector buffer write port.
module fat_chain_sector_builder #(
    parameter int          ENTRY_BITS    = 32,
    parameter int          SECTOR_BYTES  = 512,
    parameter int          RESERVED_LAST = 1,
    parameter logic [31:0] EOC_VALUE     = 32'hFFFF_FFFF,
    parameter int          BYTE_SWAP     = 0
) (
    input logic                      CLK,
    input logic                      RST_N,
    fat_chain_sector_builder_if.slave bus
);
    localparam int          WORDS  = SECTOR_BYTES / 4;
    localparam int unsigned EPW    = 32 / ENTRY_BITS;
    localparam int          EPS    = WORDS * EPW;
    localparam int          AW     = $clog2(WORDS);
    localparam int          EPS_SH = $clog2(EPS);
    localparam int          EPW_SH = $clog2(EPW);
    localparam int unsigned EBYTES = ENTRY_BITS / 8;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WRITE, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [23:0]   sect_q, sect_d;
    logic [31:0]   beg_q, beg_d;
    logic [31:0]   eof_q, eof_d;
    logic [31:0]   base_q, base_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wena_q, wena_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   word_base;

    // Rules are ordered: reserved, end-of-chain, link, free.
    function automatic logic [ENTRY_BITS-1:0] entry_val(input logic [31:0] n,
                                                        input logic [31:0] b,
                                                        input logic [31:0] e);
        logic [31:0]           v;
        logic [ENTRY_BITS-1:0] t;
        logic [ENTRY_BITS-1:0] s;
        if (n <= 32'(RESERVED_LAST)) begin
            v = EOC_VALUE;
        end else if (n == e && b <= e) begin
            v = EOC_VALUE;
        end else if (n >= b && n < e) begin
            v = n + 32'd1;
            if (ENTRY_BITS == 32) v[31:28] = 4'h0;
        end else begin
            v = '0;
        end
        t = v[ENTRY_BITS-1:0];
        s = t;
        if (BYTE_SWAP != 0) begin
            for (int unsigned i = 0; i < EBYTES; i++) begin
                s[i*8 +: 8] = t[(EBYTES-1-i)*8 +: 8];
            end
        end
        return s;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sect_q  <= '0;
            beg_q   <= '0;
            eof_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sect_q  <= sect_d;
            beg_q   <= beg_d;
            eof_q   <= eof_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.START) state_d = S_LATCH;
            S_LATCH: state_d = S_WRITE;
            S_WRITE: if (cnt_q == AW'(WORDS - 1)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign word_base = base_q + (32'(cnt_q) << EPW_SH);

    // All outputs are registered, so they are computed one state ahead here.
    always_comb begin
        sect_d  = sect_q;
        beg_d   = beg_q;
        eof_d   = eof_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        wena_d  = 1'b0;
        waddr_d = '0;
        data_d  = '0;
        busy_d  = (state_d == S_WRITE) || (state_d == S_FIN);
        done_d  = (state_q == S_FIN);
        err_d   = (state_q == S_FIN) && (eof_q < beg_q);
        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    sect_d = bus.SECTOR_IDX;
                    beg_d  = bus.BEGIN_CLUST;
                    eof_d  = bus.EOF_CLUST;
                end
            end
            S_LATCH: begin
                base_d = {8'h00, sect_q} << EPS_SH;
                cnt_d  = '0;
            end
            S_WRITE: begin
                wena_d  = 1'b1;
                waddr_d = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                for (int unsigned l = 0; l < EPW; l++) begin
                    data_d[l*ENTRY_BITS +: ENTRY_BITS] = entry_val(word_base + 32'(l), beg_q, eof_q);
                end
            end
            default: ;
        endcase
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ERR      = err_q;
    assign bus.WENA_SW  = wena_q;
    assign bus.WADDR_SW = waddr_q;
    assign bus.INPUT_SW = data_q;
endmodule

// File: tb/tb_fat_chain_sector_builder.sv
// Drives three builder configurations with shared directed/random requests and
// checks every output on every cycle against a rule-level sector model.
module tb_fat_chain_sector_builder;
    logic CLK;
    logic RST_N;

    fat_chain_sector_builder_if #(.AW(7)) ifa ();
    fat_chain_sector_builder_if #(.AW(7)) ifb ();
    fat_chain_sector_builder_if #(.AW(4)) ifc ();

    fat_chain_sector_builder u_a (
        .CLK(CLK), .RST_N(RST_N), .bus(ifa.slave)
    );
    fat_chain_sector_builder #(
        .ENTRY_BITS(16), .SECTOR_BYTES(512), .RESERVED_LAST(1),
        .EOC_VALUE(32'hFFFF_FFFF), .BYTE_SWAP(0)
    ) u_b (
        .CLK(CLK), .RST_N(RST_N), .bus(ifb.slave)
    );
    fat_chain_sector_builder #(
        .ENTRY_BITS(32), .SECTOR_BYTES(64), .RESERVED_LAST(2),
        .EOC_VALUE(32'h0FFF_FFF8), .BYTE_SWAP(1)
    ) u_c (
        .CLK(CLK), .RST_N(RST_N), .bus(ifc.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    logic [23:0] cur_s;
    logic [31:0] cur_b, cur_e;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int words_of(input int cfg);
        return (cfg == 2) ? 16 : 128;
    endfunction

    // Expected sector word straight from the chain rules, base via plain multiply.
    function automatic logic [31:0] model_word(input int cfg, input logic [23:0] s,
                                               input logic [31:0] b, input logic [31:0] e,
                                               input int w);
        int eb, words, rl, epw;
        logic [31:0] eoc, base, n, v, word;
        logic [63:0] prod;
        bit swap;
        case (cfg)
            0:       begin eb = 32; words = 128; rl = 1; eoc = 32'hFFFF_FFFF; swap = 0; end
            1:       begin eb = 16; words = 128; rl = 1; eoc = 32'hFFFF_FFFF; swap = 0; end
            default: begin eb = 32; words = 16;  rl = 2; eoc = 32'h0FFF_FFF8; swap = 1; end
        endcase
        epw  = 32 / eb;
        prod = {40'd0, s} * 64'(words * epw);
        base = prod[31:0];
        word = '0;
        for (int l = 0; l < epw; l++) begin
            n = base + 32'(w * epw + l);
            if (n <= 32'(rl)) v = eoc;
            else if (b <= e && n == e) v = eoc;
            else if (n >= b && n < e) begin
                v = n + 32'd1;
                if (eb == 32) v = v & 32'h0FFF_FFFF;
            end else v = '0;
            if (eb == 16) v = v & 32'h0000_FFFF;
            if (swap) v = (eb == 32) ? {v[7:0], v[15:8], v[23:16], v[31:24]} : {16'h0, v[7:0], v[15:8]};
            word = word | (v << (l * eb));
        end
        return word;
    endfunction

    task automatic chk_dut(input int cfg, input int cyc, input logic busy, input logic done,
                           input logic err, input logic wena, input logic [31:0] waddr,
                           input logic [31:0] data);
        int   w;
        logic beat;
        string t;
        w    = words_of(cfg);
        beat = (cyc >= 2) && (cyc <= w + 1);
        t    = $sformatf("cfg%0d_cyc%0d", cfg, cyc);
        cmp({t, "_busy"}, 32'(busy), 32'((cyc >= 1) && (cyc <= w + 1)));
        cmp({t, "_done"}, 32'(done), 32'(cyc == w + 2));
        cmp({t, "_err"},  32'(err),  32'((cyc == w + 2) && (cur_e < cur_b)));
        cmp({t, "_wena"}, 32'(wena), 32'(beat));
        cmp({t, "_waddr"}, waddr, beat ? 32'(cyc - 2) : 32'd0);
        cmp({t, "_data"}, data, beat ? model_word(cfg, cur_s, cur_b, cur_e, cyc - 2) : 32'd0);
    endtask

    task automatic chk_all(input int cyc);
        chk_dut(0, cyc, ifa.BUSY, ifa.DONE, ifa.ERR, ifa.WENA_SW, 32'(ifa.WADDR_SW), ifa.INPUT_SW);
        chk_dut(1, cyc, ifb.BUSY, ifb.DONE, ifb.ERR, ifb.WENA_SW, 32'(ifb.WADDR_SW), ifb.INPUT_SW);
        chk_dut(2, cyc, ifc.BUSY, ifc.DONE, ifc.ERR, ifc.WENA_SW, 32'(ifc.WADDR_SW), ifc.INPUT_SW);
    endtask

    task automatic chk_zero(input string tag);
        cmp({tag, "_a_ctl"}, {28'd0, ifa.BUSY, ifa.DONE, ifa.ERR, ifa.WENA_SW}, 32'd0);
        cmp({tag, "_a_addr"}, 32'(ifa.WADDR_SW), 32'd0);
        cmp({tag, "_a_data"}, ifa.INPUT_SW, 32'd0);
        cmp({tag, "_b_ctl"}, {28'd0, ifb.BUSY, ifb.DONE, ifb.ERR, ifb.WENA_SW}, 32'd0);
        cmp({tag, "_b_addr"}, 32'(ifb.WADDR_SW), 32'd0);
        cmp({tag, "_b_data"}, ifb.INPUT_SW, 32'd0);
        cmp({tag, "_c_ctl"}, {28'd0, ifc.BUSY, ifc.DONE, ifc.ERR, ifc.WENA_SW}, 32'd0);
        cmp({tag, "_c_addr"}, 32'(ifc.WADDR_SW), 32'd0);
        cmp({tag, "_c_data"}, ifc.INPUT_SW, 32'd0);
    endtask

    task automatic set_inputs(input logic [23:0] s, input logic [31:0] b, input logic [31:0] e);
        ifa.SECTOR_IDX = s; ifa.BEGIN_CLUST = b; ifa.EOF_CLUST = e;
        ifb.SECTOR_IDX = s; ifb.BEGIN_CLUST = b; ifb.EOF_CLUST = e;
        ifc.SECTOR_IDX = s; ifc.BEGIN_CLUST = b; ifc.EOF_CLUST = e;
    endtask

    // ab_pulse: extra START to a/b at that cycle; c_pulse: extra START to c;
    // abort: reset asserted at that cycle (0 = none).
    task automatic run(input logic [23:0] s, input logic [31:0] b, input logic [31:0] e,
                       input int ab_pulse, input int c_pulse, input int abort);
        cur_s = s; cur_b = b; cur_e = e;
        set_inputs(s, b, e);
        ifa.START = 1'b1; ifb.START = 1'b1; ifc.START = 1'b1;
        @(negedge CLK);
        ifa.START = 1'b0; ifb.START = 1'b0; ifc.START = 1'b0;
        set_inputs(24'($urandom), $urandom, $urandom);
        for (int cyc = 1; cyc <= 132; cyc++) begin
            @(negedge CLK);
            if (cyc == abort) begin
                ifa.START = 1'b0; ifb.START = 1'b0; ifc.START = 1'b0;
                RST_N = 1'b0;
                #1;
                chk_zero($sformatf("abort_cyc%0d", cyc));
                @(negedge CLK);
                RST_N = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    chk_zero($sformatf("after_abort%0d", k));
                end
                return;
            end
            chk_all(cyc);
            ifa.START = (cyc == ab_pulse);
            ifb.START = (cyc == ab_pulse);
            ifc.START = (cyc == c_pulse);
            if (cyc == ab_pulse || cyc == c_pulse) set_inputs(24'($urandom), $urandom, $urandom);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        ifa.START = 1'b0; ifb.START = 1'b0; ifc.START = 1'b0;
        set_inputs('0, '0, '0);
        repeat (3) @(negedge CLK);
        chk_zero("in_reset");
        RST_N = 1'b1;
        @(negedge CLK);
        chk_zero("post_reset");

        run(24'd0, 32'd2, 32'd5, 0, 0, 0);
        run(24'd1, 32'd300, 32'd301, 0, 0, 0);
        run(24'd0, 32'd4, 32'd6, 0, 0, 0);
        run(24'd0, 32'd10, 32'd8, 0, 0, 0);
        run(24'hFF_FFFF, 32'd3, 32'hFFFF_FFFF, 0, 0, 0);
        run(24'd0, 32'd2, 32'd40, 52, 0, 62);
        run(24'd0, 32'd2, 32'd5, 0, 17, 0);
        run(24'd0, 32'd0, 32'd0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            logic [31:0] rb;
            rb = $urandom_range(0, 300);
            run(24'($urandom_range(0, 2)), rb, rb + $urandom_range(0, 80) - 32'd8, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
